// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
// Accepts a big-endian byte stream (length, payload words, checksum) over a
// valid/ready handshake. It writes each payload word to consecutive word
// addresses, checks the trailing checksum, and holds the CPU stalled until a
// clean load completes.
//
// Handshake: a byte moves on a rising clock edge where byte_valid and
// byte_ready are both 1. byte_ready is decoded combinationally from the state
// register and does not depend on byte_valid. The source may present or
// withdraw byte_valid in any cycle. byte_data is only looked at on a transfer.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_CSUM  = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    // Capacity as a 32-bit value so the 32-bit length field compares directly.
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

    state_t          state;
    state_t          state_next;
    logic [1:0]      byte_cnt;
    logic [23:0]     shift_q;     // first three bytes of the word being assembled
    logic [ADDR_W:0] word_cnt;
    logic [ADDR_W:0] len_q;
    logic [31:0]     acc;

    logic            xfer;
    logic            word_end;
    logic            launch;
    logic [31:0]     full_word;
    logic [ADDR_W:0] word_cnt_inc;

    // Handshake and field-completion decode shared by the FSM and datapath.
    always_comb begin
        byte_ready   = 1'b0;
        launch       = 1'b0;
        if (state == S_LEN || state == S_DATA || state == S_CSUM) begin
            byte_ready = 1'b1;
        end
        if (state == S_IDLE || state == S_DONE || state == S_ERROR) begin
            launch = start;
        end
        xfer         = byte_valid & byte_ready;
        word_end     = xfer & (byte_cnt == 2'd3);
        full_word    = {shift_q, byte_data};
        word_cnt_inc = word_cnt + (ADDR_W+1)'(1);
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start only matters in the idle/terminal states.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (launch) state_next = S_LEN;
            end
            S_LEN: begin
                if (word_end) begin
                    if (full_word > MAX_WORDS)   state_next = S_ERROR;
                    else if (full_word == 32'd0) state_next = S_CSUM;
                    else                         state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (word_end && word_cnt_inc == len_q) state_next = S_CSUM;
            end
            S_CSUM: begin
                if (word_end) begin
                    if (full_word == acc) state_next = S_DONE;
                    else                  state_next = S_ERROR;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Byte assembly, word counting, checksum accumulation and the registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt     <= 2'd0;
            shift_q      <= 24'd0;
            word_cnt     <= '0;
            len_q        <= '0;
            acc          <= 32'd0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            imem_we  <= 1'b0;
            // The CPU may run only in DONE; follow the next state so it releases with done.
            cpu_hold <= (state_next != S_DONE);

            if (launch) begin
                byte_cnt     <= 2'd0;
                word_cnt     <= '0;
                acc          <= 32'd0;
                words_loaded <= '0;
                done         <= 1'b0;
                error        <= 1'b0;
            end

            if (xfer) begin
                byte_cnt <= byte_cnt + 2'd1;
                shift_q  <= {shift_q[15:0], byte_data};
            end

            if (word_end) begin
                case (state)
                    S_LEN: begin
                        len_q <= full_word[ADDR_W:0];
                        if (full_word > MAX_WORDS) error <= 1'b1;
                    end
                    S_DATA: begin
                        imem_we      <= 1'b1;
                        imem_addr    <= word_cnt[ADDR_W-1:0];
                        imem_wdata   <= full_word;
                        word_cnt     <= word_cnt_inc;
                        words_loaded <= word_cnt_inc;
                        acc          <= acc + full_word;
                    end
                    S_CSUM: begin
                        if (full_word == acc) done  <= 1'b1;
                        else                  error <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader.
// The reference model parses each byte stream as a whole (length, words,
// checksum) and predicts the memory writes and the final flags.
module tb_imem_loader;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 1 << ADDR_W;

  logic              clock;
  logic              reset_n;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;
  logic [2:0]        dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  stream_q[$];
  logic [39:0] exp_q[$];     // {addr, data} of each expected write, in order

  logic        exp_done;
  logic        exp_error;
  int          exp_wl;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every write strobe must match the next predicted write.
  always @(negedge clock) begin
    if (reset_n && imem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {ADDR_W'(imem_addr), imem_wdata}, 64'd0);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("write_addr", 64'(imem_addr), 64'(e[39:32]));
        check("write_data", 64'(imem_wdata), 64'(e[31:0]));
      end
    end
  end

  // ---------------- stream building and reference model ----------------
  task automatic push_word(input logic [31:0] w);
    stream_q.push_back(w[31:24]);
    stream_q.push_back(w[23:16]);
    stream_q.push_back(w[15:8]);
    stream_q.push_back(w[7:0]);
  endtask

  function automatic logic [31:0] word_at(input int idx);
    return {stream_q[idx], stream_q[idx+1], stream_q[idx+2], stream_q[idx+3]};
  endfunction

  task automatic model_stream();
    logic [31:0] n;
    logic [31:0] sum;
    n   = word_at(0);
    sum = 32'd0;
    if (n > MAX_WORDS) begin
      exp_done  = 1'b0;
      exp_error = 1'b1;
      exp_wl    = 0;
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        logic [31:0] w;
        w = word_at(4 + 4*i);
        exp_q.push_back({i[7:0], w});
        sum = sum + w;
      end
      exp_done  = (word_at(4 + 4*int'(n)) == sum);
      exp_error = !exp_done;
      exp_wl    = int'(n);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Present one byte after an idle gap and hold it until it is taken.
  task automatic send_byte(input logic [7:0] b, input int gap, input logic with_start);
    int budget;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clock);
    byte_valid = 1'b1;
    byte_data  = b;
    start      = with_start;
    budget     = 0;
    while (!byte_ready && budget < 50) begin
      @(negedge clock);
      budget++;
    end
    if (!byte_ready) check("ready_timeout", 64'(byte_ready), 64'd1);
    @(negedge clock);
    byte_valid = 1'b0;
    byte_data  = $urandom_range(0, 255);
    start      = 1'b0;
  endtask

  // Run a whole load from stream_q and check the final state.
  task automatic run_load(input string name, input int max_gap, input int start_at,
                          input logic start_on_last);
    model_stream();
    pulse_start();
    check({name, "_ready_after_start"}, 64'(byte_ready), 64'd1);
    check({name, "_wl_cleared"}, 64'(words_loaded), 64'd0);
    for (int k = 0; k < stream_q.size(); k++) begin
      if (k == start_at) pulse_start();
      send_byte(stream_q[k], $urandom_range(0, max_gap),
                start_on_last && (k == stream_q.size() - 1));
    end
    #1;
    check({name, "_done"},     64'(done),         64'(exp_done));
    check({name, "_error"},    64'(error),        64'(exp_error));
    check({name, "_cpu_hold"}, 64'(cpu_hold),     64'(!exp_done));
    check({name, "_wl"},       64'(words_loaded), 64'(exp_wl));
    check({name, "_ready"},    64'(byte_ready),   64'd0);
    check({name, "_writes"},   64'(exp_q.size()), 64'd0);
    exp_q.delete();
    stream_q.delete();
    repeat (2) @(negedge clock);
    check({name, "_no_late_write"}, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] sum;
    int          n;
    reset_n    = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    repeat (3) @(negedge clock);
    check("rst_ready",    64'(byte_ready),   64'd0);
    check("rst_we",       64'(imem_we),      64'd0);
    check("rst_addr",     64'(imem_addr),    64'd0);
    check("rst_wdata",    64'(imem_wdata),   64'd0);
    check("rst_hold",     64'(cpu_hold),     64'd1);
    check("rst_done",     64'(done),         64'd0);
    check("rst_error",    64'(error),        64'd0);
    check("rst_wl",       64'(words_loaded), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Back-to-back two-word load.
    push_word(32'd2); push_word(32'h12345678); push_word(32'h9ABCDEF0); push_word(32'hACF13568);
    run_load("b2b", 0, -1, 1'b0);

    // Same stream with random idle gaps.
    push_word(32'd2); push_word(32'h12345678); push_word(32'h9ABCDEF0); push_word(32'hACF13568);
    run_load("gaps", 5, -1, 1'b0);

    // Bad checksum: writes still happen, load ends in error.
    push_word(32'd2); push_word(32'h12345678); push_word(32'h9ABCDEF0); push_word(32'hACF13569);
    run_load("badsum", 2, -1, 1'b0);

    // Empty image.
    push_word(32'd0); push_word(32'd0);
    run_load("empty", 1, -1, 1'b0);

    // Length one above capacity stops right after the length field.
    push_word(32'd257);
    run_load("overlen", 1, -1, 1'b0);

    // Full capacity with wrapping checksum; start on the final byte is ignored.
    push_word(32'd256);
    for (int i = 0; i < 256; i++) push_word(32'hFFFFFFFF);
    push_word(32'hFFFFFF00);
    run_load("full", 0, -1, 1'b1);

    // Randomized loads, mostly with correct checksums.
    for (int t = 0; t < 6; t++) begin
      n   = $urandom_range(0, 12);
      sum = 32'd0;
      push_word(32'(n));
      for (int i = 0; i < n; i++) begin
        logic [31:0] w;
        w = $urandom;
        sum = sum + w;
        push_word(w);
      end
      if ($urandom_range(0, 3) == 0) sum = sum + 32'd1;
      push_word(sum);
      run_load("rand", 3, -1, 1'b0);
    end

    // Reset in the middle of a payload word.
    push_word(32'd2); push_word(32'hCAFEF00D); push_word(32'h0BADBEEF); push_word(32'hD6ACAEFC);
    pulse_start();
    for (int k = 0; k < 7; k++) send_byte(stream_q[k], 0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(byte_ready),   64'd0);
    check("mid_rst_we",    64'(imem_we),      64'd0);
    check("mid_rst_hold",  64'(cpu_hold),     64'd1);
    check("mid_rst_done",  64'(done),         64'd0);
    check("mid_rst_error", 64'(error),        64'd0);
    check("mid_rst_wl",    64'(words_loaded), 64'd0);
    stream_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Fresh one-word load after reset, with start pulsed during the payload.
    push_word(32'd1); push_word(32'h00C0FFEE); push_word(32'h00C0FFEE);
    run_load("after_rst", 1, 6, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory, which the pipelined CPU otherwise only reads from its IF stage. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them to consecutive instruction-memory word addresses. It verifies a trailing 32-bit checksum and holds the CPU stalled until a load completes cleanly.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity MAX_WORDS = 2**ADDR_W
- clock  in  1  single system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a new load from IDLE, DONE or ERROR
- byte_valid  in  1  source has a byte on byte_data
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle; transfer = byte_valid & byte_ready
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address of the write
- imem_wdata  out  32  word to write
- cpu_hold  out  1  stalls the CPU; drives PC write-enable low and IF/ID flush
- done  out  1  load finished, checksum matched
- error  out  1  load aborted: length overflow or checksum mismatch
- words_loaded  out  ADDR_W+1  count of words written in the current or last load

## Operation
- Stream format, all multi-byte fields big-endian (first byte = bits 31:24):
  - 4-byte length N
  - N payload words; word i is written to address i
  - 4-byte checksum = sum of all payload words mod 2^32
- States: IDLE, LEN, DATA, CSUM, DONE, ERROR.
- IDLE/DONE/ERROR + start goes to LEN. Entering LEN clears byte counter, word counter, checksum accumulator, words_loaded, done and error.
- LEN: after the 4th byte, latch N.
  - N > MAX_WORDS: go to ERROR.
  - N == 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA: every 4th byte completes a word.
  - The word is written to address = word counter, the counter increments, and the accumulator adds the word.
  - After the Nth word, go to CSUM.
- CSUM: after the 4th byte, compare with the accumulator.
  - Match: go to DONE with done=1.
  - Mismatch: go to ERROR with error=1.
- start is ignored in LEN, DATA and CSUM.
- byte_ready=1 exactly in LEN, DATA and CSUM. It is decoded combinationally from the state register.
- cpu_hold=0 only in DONE; otherwise 1. The CPU never runs from a partially written or failed image.
- byte_data is ignored when there is no transfer. byte_valid may toggle freely; gaps of any length between bytes are legal.
- Arithmetic: byte counter 2 bits, wraps 3→0 at word completion. The word counter is ADDR_W+1 bits so that N == MAX_WORDS is representable. imem_addr is the low ADDR_W bits. Checksum addition wraps silently.

## Timing
- Reset values (asynchronous, while reset_n=0):
  - state=IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0
  - cpu_hold=1, done=0, error=0, words_loaded=0
- Every output except byte_ready is registered.
- Word write latency: the 4th-byte transfer happens in cycle T; imem_we=1 in cycle T+1 with stable addr and wdata. imem_we is 0 otherwise. words_loaded increments in T+1.
- Last payload byte in cycle T: the state is CSUM in T+1, so byte_ready stays 1 with no bubble.
- Length or checksum completion in cycle T: done or error and the new state are visible in T+1, and cpu_hold drops in T+1 on success. Maximum throughput is one byte per cycle.
- reset_n asserted mid-load: immediate abort to reset values. Memory contents are undefined; there is no partial-load guarantee.
- start in the same cycle as the final CSUM byte while in CSUM: start is ignored and the load completes normally.

## Test plan
- Back-to-back, ADDR_W=8: start, then N=2, words 0x12345678 and 0x9ABCDEF0, checksum 0xACF13568 with byte_valid held 1 → imem_we in exactly 2 cycles (addr 0 ← 0x12345678, addr 1 ← 0x9ABCDEF0); done=1 and cpu_hold=0 one cycle after the last byte; words_loaded=2.
- Same stream with a random 0–5-cycle idle between every byte → identical writes and final state; no write during gaps.
- Checksum 0xACF13569 → error=1, done=0, cpu_hold stays 1; both words were still written.
- N=0 followed by checksum 0x00000000 → DONE with no imem_we. N=257 with ADDR_W=8 → ERROR right after the length, byte_ready=0, no writes.
- Wrap and capacity: N=256 of words 0xFFFFFFFF, checksum 0xFFFFFF00 → last write at addr 255, words_loaded=256, done=1.
- Assert reset_n low after the 3rd payload byte → all outputs at reset values asynchronously. After release plus start, a fresh N=1 load succeeds. start pulsed mid-DATA has no effect.
